// File: rtl/mac_window.sv
// mac_window: streaming multiply-accumulate over a sliding window of
// N = 2P+1 consecutive valid samples.
// Result = sum of w[2i]*w[2i+1] for i < P, plus w[2P].
// The datapath is two registered stages: products, then sum/saturate.
// Overflow is reported whenever the full-precision sum does not fit in DW bits.
module mac_window #(
  parameter int DW  = 32,
  parameter int P   = 1,
  parameter bit SAT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          validi,
  input  logic [DW-1:0] data_in,
  output logic          valido,
  output logic [DW-1:0] data_out,
  output logic          ovf,
  output logic          primed
);

  localparam int N  = 2 * P + 1;
  localparam int FW = $clog2(N + 1);
  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + $clog2(P + 1);

  // Window and fill tracking
  logic [DW-1:0] win_q [N];
  logic [DW-1:0] win_d [N];
  logic [FW-1:0] fill_q, fill_d;
  logic          primed_q, primed_d;

  // Stage 1: products and addend
  logic [PW-1:0] prod_q [P];
  logic [PW-1:0] prod_d [P];
  logic [DW-1:0] addend_q, addend_d;
  logic          s1_valid_q, s1_valid_d;

  // Stage 2: output registers
  logic          valid_out_q, valid_out_d;
  logic [DW-1:0] data_q, data_d;
  logic          ovf_q, ovf_d;

  // Full-precision sum of stage-1 contents
  logic [SW-1:0] sum;
  logic          sum_ovf;

  // Shift a new sample into the window and track the run length; a gap or flush restarts the run
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clr) begin
      fill_d = '0;
    end else if (validi) begin
      for (int i = 0; i < N - 1; i++) begin
        win_d[i] = win_q[i + 1];
      end
      win_d[N-1] = data_in;
      if (fill_q != FW'(N)) begin
        fill_d = fill_q + FW'(1);
      end
    end else begin
      fill_d = '0;
    end
    primed_d = (fill_d == FW'(N));
  end

  // Form pair products from a full window; primed_q means the last edge completed a window
  always_comb begin
    prod_d     = prod_q;
    addend_d   = addend_q;
    s1_valid_d = primed_q && !clr;
    if (primed_q) begin
      for (int i = 0; i < P; i++) begin
        prod_d[i] = PW'(win_q[2*i]) * PW'(win_q[2*i+1]);
      end
      addend_d = win_q[2*P];
    end
  end

  // Add products and addend at full width, then wrap or saturate into the output registers
  always_comb begin
    sum = SW'(addend_q);
    for (int i = 0; i < P; i++) begin
      sum = sum + SW'(prod_q[i]);
    end
    sum_ovf = |sum[SW-1:DW];

    valid_out_d = s1_valid_q && !clr;
    data_d      = data_q;
    ovf_d       = ovf_q;
    if (s1_valid_q && !clr) begin
      data_d = (SAT && sum_ovf) ? {DW{1'b1}} : sum[DW-1:0];
      ovf_d  = sum_ovf;
    end
  end

  // State registers with asynchronous reset clearing window, pipeline and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
      for (int i = 0; i < P; i++) begin
        prod_q[i] <= '0;
      end
      fill_q      <= '0;
      primed_q    <= 1'b0;
      addend_q    <= '0;
      s1_valid_q  <= 1'b0;
      valid_out_q <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      win_q       <= win_d;
      prod_q      <= prod_d;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
      addend_q    <= addend_d;
      s1_valid_q  <= s1_valid_d;
      valid_out_q <= valid_out_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign valido   = valid_out_q;
  assign data_out = data_q;
  assign ovf      = ovf_q;
  assign primed   = primed_q;

endmodule
